// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and RAM port signals shared by the
// single-port RAM arbiter and whatever sits on either side of it.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] rdata;
    logic        busy;
    logic [31:0] ram_data_out;
    logic [31:0] ram_data_in;
    logic [31:0] address;
    logic        cs;
    logic        we;
    logic        oe;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_data_out,
        output if_done, ls_done, rdata, busy, ram_data_in, address, cs, we, oe
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ram_data_out,
        input  if_done, ls_done, rdata, busy, ram_data_in, address, cs, we, oe
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between instruction fetch and
// load/store; every access runs IDLE -> ACCESS (RAM_LAT cycles) -> DONE.
module mem_port_arbiter #(
    parameter int unsigned RAM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
    typedef enum logic {GNT_IF, GNT_LS} grant_e;

    localparam logic [2:0] CNT_INIT = 3'(RAM_LAT - 1);

    state_e      state_q, state_d;
    grant_e      last_q, last_d;
    grant_e      cur_q, cur_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        cs_q, cs_d;
    logic        we_q, we_d;
    logic        oe_q, oe_d;
    logic [31:0] address_q, address_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        if_done_q, if_done_d;
    logic        ls_done_q, ls_done_d;
    logic        busy_q, busy_d;
    logic        pick_ls;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= GNT_IF;
            cur_q     <= GNT_IF;
            cnt_q     <= '0;
            cs_q      <= 1'b0;
            we_q      <= 1'b0;
            oe_q      <= 1'b0;
            address_q <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            if_done_q <= 1'b0;
            ls_done_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cur_q     <= cur_d;
            cnt_q     <= cnt_d;
            cs_q      <= cs_d;
            we_q      <= we_d;
            oe_q      <= oe_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            if_done_q <= if_done_d;
            ls_done_q <= ls_done_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        cs_d      = cs_q;
        we_d      = we_q;
        oe_d      = oe_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        if_done_d = 1'b0;
        ls_done_d = 1'b0;
        busy_d    = busy_q;
        pick_ls   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.if_req || bus.ls_req) begin
                    // On contention the side that did not win last time goes first.
                    pick_ls = bus.ls_req && (!bus.if_req || last_q == GNT_IF);
                    cur_d   = pick_ls ? GNT_LS : GNT_IF;
                    last_d  = cur_d;
                    cs_d    = 1'b1;
                    cnt_d   = CNT_INIT;
                    busy_d  = 1'b1;
                    state_d = ACCESS;
                    if (pick_ls) begin
                        address_d = bus.ls_addr;
                        we_d      = bus.ls_we;
                        oe_d      = !bus.ls_we;
                        if (bus.ls_we) begin
                            wdata_d = bus.ls_wdata;
                        end
                    end else begin
                        address_d = {bus.if_addr[31:2], 2'b00};
                        we_d      = 1'b0;
                        oe_d      = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    if (!we_q) begin
                        rdata_d = bus.ram_data_out;
                    end
                    cs_d      = 1'b0;
                    we_d      = 1'b0;
                    oe_d      = 1'b0;
                    if_done_d = (cur_q == GNT_IF);
                    ls_done_d = (cur_q == GNT_LS);
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.cs          = cs_q;
    assign bus.we          = we_q;
    assign bus.oe          = oe_q;
    assign bus.address     = address_q;
    assign bus.ram_data_in = wdata_q;
    assign bus.rdata       = rdata_q;
    assign bus.if_done     = if_done_q;
    assign bus.ls_done     = ls_done_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed cases plus random
// single-requester traffic checked against a shadow-memory reference.
module tb_mem_port_arbiter;
    localparam int unsigned RAM_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.RAM_LAT(RAM_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural RAM: combinational read, write committed on clock edges with cs&we.
    logic [31:0] mem [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    assign bus.ram_data_out = mem[bus.address[9:2]];

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_val;
        else if (bus.cs && bus.we) mem[bus.address[9:2]] <= bus.ram_data_in;
    end

    // Reference state: expected memory contents and last read value.
    logic [31:0] shadow [256];
    logic [31:0] model_rdata;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_access(input bit is_ls, input bit wr, input logic [31:0] addr,
                             input logic [31:0] wd, input bit drop);
        logic [31:0] exp_addr;
        logic [31:0] exp_rd;
        exp_addr = is_ls ? addr : (addr & 32'hFFFF_FFFC);
        exp_rd   = wr ? model_rdata : shadow[exp_addr[9:2]];
        if (is_ls) begin
            bus.ls_req = 1'b1; bus.ls_we = wr; bus.ls_addr = addr; bus.ls_wdata = wd;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        for (int c = 0; c < int'(RAM_LAT); c++) begin
            @(negedge clk);
            chk("acc_cs", bus.cs, 1);
            chk("acc_we", bus.we, wr);
            chk("acc_oe", bus.oe, !wr);
            chk("acc_addr", bus.address, exp_addr);
            if (wr) chk("acc_wdata", bus.ram_data_in, wd);
            chk("acc_busy", bus.busy, 1);
            chk("acc_if_done", bus.if_done, 0);
            chk("acc_ls_done", bus.ls_done, 0);
            if (drop && c == 0) begin
                bus.ls_req = 1'b0; bus.if_req = 1'b0;
            end
        end
        @(negedge clk);
        chk("done_cs", {bus.cs, bus.we, bus.oe}, 0);
        chk("done_if", bus.if_done, !is_ls);
        chk("done_ls", bus.ls_done, is_ls);
        chk("done_rdata", bus.rdata, exp_rd);
        chk("done_busy", bus.busy, 1);
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        if (wr) shadow[exp_addr[9:2]] = wd;
        model_rdata = exp_rd;
        @(negedge clk);
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", {bus.if_done, bus.ls_done}, 0);
        chk("idle_cs", bus.cs, 0);
    endtask

    initial begin
        int          pulses;
        int          last_cyc;
        bit          exp_ls;
        logic [31:0] v;

        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0;
        model_rdata = '0;

        // Preload RAM and shadow with identical random contents while in reset.
        for (int i = 0; i < 256; i++) begin
            v = (i == 64) ? 32'hE3A01005 : $urandom;
            shadow[i] = v;
            @(negedge clk);
            pl_en = 1'b1; pl_idx = 8'(i); pl_val = v;
        end
        @(negedge clk);
        pl_en = 1'b0;
        @(negedge clk);
        chk("rst_ctrl", {bus.cs, bus.we, bus.oe, bus.busy}, 0);
        chk("rst_done", {bus.if_done, bus.ls_done}, 0);
        chk("rst_addr", bus.address, 0);
        chk("rst_wdata", bus.ram_data_in, 0);
        chk("rst_rdata", bus.rdata, 0);
        rst = 1'b0;

        do_access(0, 0, 32'h100, 0, 0);
        chk("fetch_rdata", bus.rdata, 32'hE3A01005);
        do_access(1, 1, 32'h200, 32'hDEADBEEF, 0);
        do_access(0, 0, 32'h103, 0, 0);
        do_access(1, 0, 32'h200, 0, 0);

        // Both requesters held high from reset: grants alternate starting with ls.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; model_rdata = '0;
        bus.if_req = 1'b1; bus.if_addr = 32'h10;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 32'h20;
        pulses = 0; last_cyc = 0; exp_ls = 1'b1;
        for (int cyc = 1; cyc <= 40 && pulses < 4; cyc++) begin
            @(negedge clk);
            if (bus.if_done || bus.ls_done) begin
                chk("rr_order_ls", bus.ls_done, exp_ls);
                chk("rr_order_if", bus.if_done, !exp_ls);
                chk("rr_spacing", cyc - last_cyc,
                    (pulses == 0) ? RAM_LAT + 1 : RAM_LAT + 2);
                last_cyc = cyc;
                exp_ls = !exp_ls;
                pulses++;
            end
        end
        bus.if_req = 1'b0; bus.ls_req = 1'b0;
        chk("rr_pulses", pulses, 4);
        @(negedge clk);
        chk("rr_idle", bus.busy, 0);

        // Reset during the first ACCESS cycle aborts without a done pulse.
        bus.if_req = 1'b1; bus.if_addr = 32'h80;
        @(negedge clk);
        chk("abort_cs_pre", bus.cs, 1);
        rst = 1'b1; bus.if_req = 1'b0;
        @(negedge clk);
        chk("abort_ctrl", {bus.cs, bus.we, bus.oe, bus.busy}, 0);
        chk("abort_done", {bus.if_done, bus.ls_done}, 0);
        rst = 1'b0; model_rdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_quiet", {bus.if_done, bus.ls_done, bus.busy}, 0);
        end
        do_access(1, 0, 32'h40, 0, 0);

        // Request dropped mid-access still completes, then no new grant.
        do_access(1, 0, 32'h44, 0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("drop_quiet", {bus.cs, bus.busy, bus.ls_done}, 0);
        end

        for (int n = 0; n < 24; n++) begin
            bit is_ls;
            bit wr;
            is_ls = 1'($urandom_range(0, 1));
            wr    = is_ls ? 1'($urandom_range(0, 1)) : 1'b0;
            do_access(is_ls, wr, 32'($urandom_range(0, 1023)), $urandom,
                      1'($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
